// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and constants for the fifo write arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   STAT_W      : width of every statistics counter
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// fifo_arb_rr_pick
//   Combinational round-robin picker: finds the first set request bit at or
//   after rr_ptr, wrapping past NUM_REQ-1 back to 0.
//   Ports:
//     req    in  NUM_REQ  request vector
//     rr_ptr in  PTR_W    index with highest priority (must be < NUM_REQ)
//     any    out 1        at least one request bit is set
//     idx    out PTR_W    index of the selected request (0 when any=0)
module fifo_arb_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic               any,
   output logic [PTR_W-1:0]   idx
);

   localparam int unsigned N = NUM_REQ;

   always_comb begin
      int unsigned      pos;
      logic [PTR_W-1:0] p;
      logic             found;
      any   = |req;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      p     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         // explicit wrap so non-power-of-2 NUM_REQ never indexes past the end
         pos = 32'(rr_ptr) + k;
         if (pos >= N) pos = pos - N;
         p = PTR_W'(pos);
         if (!found && req[p]) begin
            found = 1'b1;
            idx   = p;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one fifo write port between NUM_REQ
//   valid/ready producers. A grant lasts up to MAX_BURST beats, ends early
//   when the holder drops valid, and costs one idle cycle to re-arbitrate.
//   fifo_full stalls the holder without releasing it.
//   Optional statistics: define FIFO_ARB_STATS_EN to build the saturating
//   per-requester beat counters and the full-stall counter; otherwise the
//   stat_* ports are tied to 0.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     req_valid/_data  producer beats (requester i at [i*DATA_W +: DATA_W])
//     req_ready        one-hot (or zero) ready back to producers
//     fifo_data_in     write data to fifo (0 when not writing)
//     fifo_write_en    write strobe to fifo
//     fifo_full        fifo full flag
//     gnt_id           current/last grant holder
//     gnt_active       grant in progress
//     stat_beats       per-requester beat counters, STAT_W bits each
//     stat_stall       grant cycles stalled by fifo_full
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]           fifo_data_in,
   output logic                        fifo_write_en,
   input  logic                        fifo_full,
   output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
   output logic                        gnt_active,
   output logic [NUM_REQ*STAT_W-1:0]   stat_beats,
   output logic [STAT_W-1:0]           stat_stall
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   arb_state_e       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [BC_W-1:0]  beat_cnt;

   logic             pick_any;
   logic [PTR_W-1:0] pick_idx;
   logic             grant_open;
   logic             vld_sel;
   logic [DATA_W-1:0] data_sel;
   logic             transfer;
   logic             burst_end;
   logic [PTR_W-1:0] next_ptr;

   fifo_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr),
      .any    (pick_any),
      .idx    (pick_idx)
   );

   // rst_n gates the handshake so nothing is written while reset is held
   assign grant_open = rst_n & (state == GRANT) & ~fifo_full;

   always_comb begin
      req_ready = '0;
      vld_sel   = 1'b0;
      data_sel  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == PTR_W'(i)) begin
            req_ready[i] = grant_open;
            vld_sel      = req_valid[i];
            data_sel     = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign transfer      = grant_open & vld_sel;
   assign fifo_write_en = transfer;
   assign fifo_data_in  = transfer ? data_sel : '0;
   assign gnt_active    = (state == GRANT);

   assign burst_end = (beat_cnt == BC_W'(MAX_BURST - 1));
   assign next_ptr  = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         gnt_id   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state    <= GRANT;
                  gnt_id   <= pick_idx;
                  beat_cnt <= '0;
               end
            end
            GRANT: begin
               // full alone never releases; only a dropped valid or a
               // completed burst hands the port on
               if (!vld_sel || (transfer && burst_end)) begin
                  state    <= IDLE;
                  rr_ptr   <= next_ptr;
                  beat_cnt <= '0;
               end else if (transfer) begin
                  beat_cnt <= beat_cnt + BC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [STAT_W-1:0] beats_q [NUM_REQ];
   logic [STAT_W-1:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) beats_q[i] <= '0;
         stall_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (transfer && (gnt_id == PTR_W'(i)) && (beats_q[i] != '1))
               beats_q[i] <= beats_q[i] + STAT_W'(1);
         end
         if ((state == GRANT) && vld_sel && fifo_full && (stall_q != '1))
            stall_q <= stall_q + STAT_W'(1);
      end
   end

   always_comb begin
      stat_beats = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         stat_beats[i*STAT_W +: STAT_W] = beats_q[i];
   end
   assign stat_stall = stall_q;
`else
   assign stat_beats = '0;
   assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=4) with a
//   grant/budget reference model. Stat expectations follow FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_ready;
   logic [DW-1:0] fifo_data_in;
   logic          fifo_write_en;
   logic          fifo_full;
   logic [1:0]    gnt_id;
   logic          gnt_active;
   logic [NR*16-1:0] stat_beats;
   logic [15:0]   stat_stall;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ   (NR),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fifo_data_in  (fifo_data_in),
      .fifo_write_en (fifo_write_en),
      .fifo_full     (fifo_full),
      .gnt_id        (gnt_id),
      .gnt_active    (gnt_active),
      .stat_beats    (stat_beats),
      .stat_stall    (stat_stall)
   );

   int vectors = 0;
   int miscompares = 0;

   // reference model: who holds the port, how many beats it has used,
   // and where the next search starts
   bit m_active;
   int m_gid, m_ptr, m_used;
   int m_beats[NR];
   int m_stall;

   // producer side bookkeeping (driven from observed handshakes)
   int pending[NR];
   int sent[NR];
   int log_id[$];
   int log_data[$];
   int log_cyc[$];
   int cyc = 0;

   logic [15:0] o_vec, e_vec;

   task automatic model_reset();
      m_active = 0; m_gid = 0; m_ptr = 0; m_used = 0; m_stall = 0;
      for (int i = 0; i < NR; i++) m_beats[i] = 0;
   endtask

   task automatic drive_pattern();
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = (pending[i] > 0);
         req_data[i*DW +: DW] = 8'((i * 16 + sent[i]) & 8'hFF);
      end
   endtask

   // one clock: sample outputs + model prediction, then advance the model
   task automatic tick();
      logic [NR-1:0] e_ready;
      logic          e_we;
      logic [DW-1:0] e_data;
      @(negedge clk);
      e_ready = '0; e_we = 1'b0; e_data = '0;
      if (rst_n && m_active && !fifo_full) begin
         e_ready[m_gid] = 1'b1;
         if (req_valid[m_gid]) begin
            e_we   = 1'b1;
            e_data = req_data[m_gid*DW +: DW];
         end
      end
      e_vec = {e_ready, e_we, e_data, m_active, 2'(m_gid)};
      o_vec = {req_ready, fifo_write_en, fifo_data_in, gnt_active, gnt_id};
      if (fifo_write_en === 1'b1) begin
         log_id.push_back(int'(gnt_id));
         log_data.push_back(int'(fifo_data_in));
         log_cyc.push_back(cyc);
      end
      for (int i = 0; i < NR; i++)
         if (req_valid[i] && req_ready[i] === 1'b1) begin
            sent[i]++;
            if (pending[i] > 0) pending[i]--;
         end
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (!m_active) begin
         for (int k = 0; k < NR; k++) begin
            int c;
            c = (m_ptr + k) % NR;
            if (!m_active && req_valid[c]) begin
               m_active = 1; m_gid = c; m_used = 0;
            end
         end
      end else begin
         if (req_valid[m_gid] && fifo_full) m_stall++;
         if (e_we) begin
            m_beats[m_gid]++;
            m_used++;
         end
         if (!req_valid[m_gid] || m_used == MB) begin
            m_active = 0;
            m_ptr = (m_gid + 1) % NR;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic clear_log();
      log_id.delete(); log_data.delete(); log_cyc.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '1; req_data = 32'hA5A5_A5A5; fifo_full = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL reset cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      vectors++;
      if ({stat_beats, stat_stall} !== '0) begin
         miscompares++;
         $display("FAIL reset_stats got %h/%h want 0", stat_beats, stat_stall);
      end
      rst_n = 1'b1; req_valid = '0;
   endtask

   task automatic test_round_robin();
      int t0, n;
      pending[0] = 8; pending[1] = 4; pending[2] = 4; pending[3] = 4;
      clear_log(); t0 = cyc; n = 0;
      while (log_id.size() < 20 && n < 60) begin
         drive_pattern(); tick(); n++;
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL rr cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      for (int j = 0; j < 2; j++) begin
         drive_pattern(); tick();
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL rr_idle cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      vectors++;
      if (log_id.size() != 20) begin
         miscompares++;
         $display("FAIL rr_count got %0d want 20", log_id.size());
      end
      for (int k = 0; k < 20 && k < log_id.size(); k++) begin
         int eid, ed, ec;
         eid = (k / 4) % 4;
         ed  = eid * 16 + (k / 16) * 4 + k % 4;
         ec  = t0 + 1 + k + k / 4;
         vectors++;
         if (log_id[k] != eid || log_data[k] != ed || log_cyc[k] != ec) begin
            miscompares++;
            $display("FAIL rr_write[%0d] got id%0d d%0d c%0d want id%0d d%0d c%0d",
                     k, log_id[k], log_data[k], log_cyc[k], eid, ed, ec);
         end
      end
   endtask

   task automatic test_early_drop();
      int eid[6] = '{2, 2, 3, 3, 3, 3};
      int ed[6]  = '{36, 37, 52, 53, 54, 55};
      pending[2] = 2; pending[3] = 4;
      clear_log();
      for (int n = 0; n < 12; n++) begin
         drive_pattern(); tick();
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL drop cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      vectors++;
      if (log_id.size() != 6) begin
         miscompares++;
         $display("FAIL drop_count got %0d want 6", log_id.size());
      end
      for (int k = 0; k < 6 && k < log_id.size(); k++) begin
         vectors++;
         if (log_id[k] != eid[k] || log_data[k] != ed[k]) begin
            miscompares++;
            $display("FAIL drop_write[%0d] got id%0d d%0d want id%0d d%0d",
                     k, log_id[k], log_data[k], eid[k], ed[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int stall_end;
      int exp_stall;
      pending[0] = 4;
      clear_log();
      fifo_full = 1'b0; drive_pattern(); tick();       // arbitration bubble
      for (int n = 0; n < 14; n++) begin
         fifo_full = (n < 6);
         drive_pattern(); tick();
         if (n == 5) stall_end = cyc;
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL bp cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      fifo_full = 1'b0;
      vectors++;
      if (log_id.size() != 4) begin
         miscompares++;
         $display("FAIL bp_count got %0d want 4", log_id.size());
      end
      for (int k = 0; k < log_id.size(); k++) begin
         vectors++;
         if (log_id[k] != 0 || log_data[k] != 8 + k || log_cyc[k] < stall_end) begin
            miscompares++;
            $display("FAIL bp_write[%0d] got id%0d d%0d c%0d want id0 d%0d c>=%0d",
                     k, log_id[k], log_data[k], log_cyc[k], 8 + k, stall_end);
         end
      end
`ifdef FIFO_ARB_STATS_EN
      exp_stall = 6;
`else
      exp_stall = 0;
`endif
      vectors++;
      if (int'(stat_stall) != exp_stall) begin
         miscompares++;
         $display("FAIL bp_stat_stall got %0d want %0d", stat_stall, exp_stall);
      end
   endtask

   task automatic test_reset_mid_burst();
      int eid[9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
      int ed[9]  = '{12, 13, 14, 22, 23, 24, 25, 26, 27};
      pending[1] = 8; pending[0] = 3;
      for (int n = 0; n < 3; n++) begin                // bubble + beats 0,1 of req 1
         drive_pattern(); tick();
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL rstmid_pre cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      rst_n = 1'b0; drive_pattern(); tick();
      vectors++;
      if (fifo_write_en !== 1'b0 || req_ready !== '0) begin
         miscompares++;
         $display("FAIL rstmid_we got we%b rdy%b want we0 rdy0", fifo_write_en, req_ready);
      end
      rst_n = 1'b1;
      clear_log();
      for (int n = 0; n < 25; n++) begin
         drive_pattern(); tick();
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL rstmid cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      vectors++;
      if (log_id.size() != 9) begin
         miscompares++;
         $display("FAIL rstmid_count got %0d want 9", log_id.size());
      end
      for (int k = 0; k < 9 && k < log_id.size(); k++) begin
         vectors++;
         if (log_id[k] != eid[k] || log_data[k] != ed[k]) begin
            miscompares++;
            $display("FAIL rstmid_write[%0d] got id%0d d%0d want id%0d d%0d",
                     k, log_id[k], log_data[k], eid[k], ed[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (pending[i] == 0 && $urandom_range(0, 5) == 0)
               pending[i] = int'($urandom_range(1, 9));
            req_valid[i] = (pending[i] > 0) && ($urandom_range(0, 7) != 0);
         end
         req_data  = $urandom;
         fifo_full = ($urandom_range(0, 4) == 0);
         rst_n     = ($urandom_range(0, 149) != 0);
         tick();
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL random cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      rst_n = 1'b1; fifo_full = 1'b0;
      for (int i = 0; i < NR; i++) pending[i] = 0;
      for (int n = 0; n < 3; n++) begin
         drive_pattern(); tick();
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL random_drain cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
   endtask

   task automatic test_stats();
      int n;
      logic [NR*16-1:0] e_beats;
      rst_n = 1'b0; req_valid = '0; tick();
      rst_n = 1'b1;
      pending[0] = 300; n = 0;
      while (pending[0] > 0 && n < 500) begin
         drive_pattern(); tick(); n++;
         vectors++;
         if (o_vec !== e_vec) begin
            miscompares++;
            $display("FAIL stats300 cyc=%0d got %h want %h", cyc, o_vec, e_vec);
         end
      end
      drive_pattern(); tick(); drive_pattern(); tick();
      e_beats = '0;
`ifdef FIFO_ARB_STATS_EN
      e_beats[15:0] = 16'd300;
`endif
      vectors++;
      if (stat_beats !== e_beats || stat_stall !== 16'd0) begin
         miscompares++;
         $display("FAIL stats300 got %h/%h want %h/0000", stat_beats, stat_stall, e_beats);
      end
`ifdef FIFO_ARB_STATS_EN
      pending[0] = 65540 - 300; n = 0;
      while (pending[0] > 0 && n < 90000) begin
         drive_pattern(); tick(); n++;
      end
      vectors++;
      if (pending[0] != 0) begin
         miscompares++;
         $display("FAIL stats_sat_timeout pending got %0d want 0", pending[0]);
      end
      drive_pattern(); tick();
      vectors++;
      if (stat_beats[15:0] !== 16'hFFFF || m_beats[0] < 65535) begin
         miscompares++;
         $display("FAIL stats_sat got %h want ffff (model beats %0d)", stat_beats[15:0], m_beats[0]);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '1; req_data = '0; fifo_full = 1'b0;
      for (int i = 0; i < NR; i++) begin pending[i] = 0; sent[i] = 0; end
      model_reset();
      @(posedge clk); #1;
      test_reset();
      test_round_robin();
      test_early_drop();
      test_backpressure();
      test_reset_mid_burst();
      test_random();
      test_stats();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
